// File: rtl/seq_detect.sv
// Purpose : serial bit-pattern detector with a Mealy match flag and a saturating match counter.
// Latency : qout is combinational from din (zero cycles); match_cnt updates on the next clk edge.
// Backpressure: none; din_valid qualifies each bit and idle cycles simply hold the history.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-low reset
//   din        - serial data bit
//   din_valid  - din is sampled this cycle
//   cfg_load   - latch cfg_pat/cfg_ovl and restart detection (overrides din this cycle)
//   cfg_pat    - pattern, MSB is the first bit received
//   cfg_ovl    - 1 = overlapping detection, 0 = non-overlapping
//   cnt_clr    - synchronous clear of match_cnt
//   qout       - match flag, combinational from din
//   match_cnt  - registered saturating match count
module seq_detect #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic             cfg_ovl,
    input  logic             cnt_clr,
    output logic             qout,
    output logic [CNT_W-1:0] match_cnt
);

    // fill never exceeds PAT_W-1, which always fits in clog2(PAT_W) bits for PAT_W >= 2
    localparam int                 FILL_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic [PAT_W-1:0]  window;

    // The candidate window is the stored history with the live bit appended as newest.
    assign accept = din_valid && !cfg_load;
    assign window = {hist_q, din};

    always_comb begin
        qout = 1'b0;
        if (accept && (fill_q == FILL_MAX) && (window == pat_q)) begin
            qout = 1'b1;
        end
    end

    // History / configuration next state
    always_comb begin
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;

        if (cfg_load) begin
            pat_d  = cfg_pat;
            ovl_d  = cfg_ovl;
            fill_d = '0;
        end else if (accept) begin
            if (qout && !ovl_q) begin
                // Non-overlapping: the matched bits are consumed, restart from empty.
                fill_d = '0;
            end else begin
                hist_d = window[PAT_W-2:0];
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end
    end

    // Counter next state: a clear coinciding with a match leaves the new match counted.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = qout ? CNT_W'(1) : '0;
        end else if (qout && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= '0;
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;

endmodule

// File: doc/seq_detect.md
SEQ_DETECT -- requirements
Module: seq_detect

Parameters
REQ-001 The block SHALL have parameter PAT_W, default 4, giving the pattern length in bits; legal values are 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the match-counter width.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port din, input, 1 bit: serial data bit.
REQ-006 The block SHALL have port din_valid, input, 1 bit: din is sampled this cycle.
REQ-007 The block SHALL have port cfg_load, input, 1 bit: latch a new configuration this cycle.
REQ-008 The block SHALL have port cfg_pat, input, PAT_W bits: pattern; the MSB is the first bit received.
REQ-009 The block SHALL have port cfg_ovl, input, 1 bit: 1 selects overlapping detection, 0 selects non-overlapping detection.
REQ-010 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of match_cnt.
REQ-011 The block SHALL have port qout, output, 1 bit: Mealy match flag, combinational from the current din.
REQ-012 The block SHALL have port match_cnt, output, CNT_W bits: registered, saturating count of matches.

Function
REQ-013 Internal state SHALL be:
- pat_r (PAT_W bits);
- ovl_r (1 bit);
- hist (PAT_W-1 bits): the most recent accepted bits, newest in the LSB;
- fill: count of valid bits in hist, saturating at PAT_W-1.
REQ-014 A cycle SHALL be an accept cycle when din_valid=1 and cfg_load=0.
REQ-015 qout SHALL be 1 only when all of these hold in the same cycle:
- accept cycle;
- fill == PAT_W-1;
- {hist, din} == pat_r.
qout SHALL be 0 in every other case, with zero-cycle latency from din.
REQ-016 On an accept cycle with qout=0:
- hist SHALL shift left, taking din into the LSB;
- fill SHALL increment, saturating at PAT_W-1.
REQ-017 On an accept cycle with qout=1 and ovl_r=1, hist and fill SHALL update exactly as in REQ-016, so that overlapping matches are found.
REQ-018 On an accept cycle with qout=1 and ovl_r=0:
- fill SHALL be set to 0;
- hist contents become don't-care.
Detection restarts from an empty history.
REQ-019 When din_valid=0 and cfg_load=0, hist, fill, pat_r and ovl_r SHALL hold.
REQ-020 When cfg_load=1:
- pat_r SHALL take cfg_pat and ovl_r SHALL take cfg_ovl;
- fill SHALL clear to 0;
- din is ignored that cycle, whatever din_valid is, and qout=0 (cfg_load has priority over din).
REQ-021 cfg_pat and cfg_ovl changes without cfg_load SHALL have no effect.
REQ-022 match_cnt SHALL update as follows:
- cnt_clr=1 and qout=0: match_cnt becomes 0;
- cnt_clr=1 and qout=1 in the same cycle: match_cnt becomes 1;
- otherwise: match_cnt increments on each qout=1 cycle, holding at 2^CNT_W-1 without wrapping.
REQ-023 cnt_clr SHALL NOT affect hist, fill or the configuration.
REQ-024 The block SHALL use one clock domain only; there are no gated clocks.

Reset
REQ-025 While rst=0, regardless of clk, the block SHALL force:
- pat_r = 0 and ovl_r = 1;
- hist = 0 and fill = 0;
- match_cnt = 0;
- qout = 0, which follows from fill=0.
REQ-026 Reset asserted mid-stream SHALL discard any partial match; after release, PAT_W accepted bits are needed before any match.
REQ-027 Release of rst SHALL take effect at the first rising clk edge after deassertion; no cycle after release depends on pre-reset history.

Verification
REQ-028 Overlap test: with PAT_W=4, cfg_pat=4'b1001 and cfg_ovl=1, send stream 1,0,0,1,0,0,1. Required response: qout=1 on bits 4 and 7 only; match_cnt=2.
REQ-029 Non-overlap test: use the same stream with cfg_ovl=0. Required response: qout=1 on bit 4 only; match_cnt=1.
REQ-030 Gaps test: send the pattern 1,0,0,1 with din_valid=0 idle cycles between bits. Required response: qout=1 only on the cycle the last bit is accepted; qout=0 during the gaps.
REQ-031 Config-collision test: after 1,0,0, assert cfg_load=1 with din=1 and din_valid=1 in the same cycle. Required response: qout=0; fill=0; the next match needs 4 fresh bits.
REQ-032 Saturation test: with CNT_W=2, produce 5 matches, asserting cnt_clr on the 5th match cycle. Required response: match_cnt goes 1,2,3,3, then becomes 1.
REQ-033 Reset test: assert rst=0 asynchronously, mid-cycle, after bits 1,0,0. Required response: match_cnt=0 and qout=0 immediately; after release and reload, input 1 alone does not match.
